// File: rtl/calcu_pkg.sv
// calcu_pkg: shared FSM state encoding and ALU opcode constants for the calculator front end
package calcu_pkg;
  typedef enum logic [2:0] {ST_A = 3'd0, ST_B, ST_OP, ST_EXEC, ST_RES} state_t;
  localparam logic [3:0] OP_SUMA   = 4'd0;
  localparam logic [3:0] OP_RESTA  = 4'd1;
  localparam logic [3:0] OP_MULT   = 4'd2;
  localparam logic [3:0] OP_MOD    = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_AND    = 4'd5;
  localparam logic [3:0] OP_OR     = 4'd6;
  localparam logic [3:0] OP_XOR    = 4'd7;
  localparam logic [3:0] OP_LSHIFT = 4'd8;
  localparam logic [3:0] OP_RSHIFT = 4'd9;
  localparam logic [3:0] OP_MAX    = OP_RSHIFT;
  function automatic logic op_ok(input logic [3:0] op);
    return op <= OP_MAX;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, optional debounce (CALCU_DEBOUNCE_EN), 1-cycle press pulse on accepted rise
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  logic [1:0] sync;
  logic level, level_q;
  // bring the asynchronous button into the clock domain
  always_ff @(posedge clk)
    if (rst) sync <= '0;
    else sync <= {sync[0], btn};
`ifdef CALCU_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [CW-1:0] cnt;
  logic samp_q;
  // accept a level only once it has been sampled DEBOUNCE_CYCLES times in a row
  always_ff @(posedge clk)
    if (rst) begin
      samp_q <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      samp_q <= sync[1];
      cnt    <= sync[1] != samp_q ? '0 : cnt == CW'(DEBOUNCE_CYCLES - 1) ? cnt : cnt + 1'b1;
      level  <= cnt == CW'(DEBOUNCE_CYCLES - 1) ? samp_q : level;
    end
`else
  localparam int unused_cycles = DEBOUNCE_CYCLES;
  assign level = sync[1];
`endif
  // registered rising-edge detect of the accepted level
  always_ff @(posedge clk)
    if (rst) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
endmodule

// File: rtl/calcu_input_seq.sv
// calcu_input_seq: switch/button sequencer capturing A, B and opcode for the ALU, then latching its result (CALCU_DEBOUNCE_EN enables button debounce)
module calcu_input_seq
  import calcu_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic         btn_next,
  input  logic         btn_clr,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [3:0]   seleccion,
  input  logic [N-1:0] salida_in,
  input  logic [3:0]   flags_in,
  output logic [N-1:0] res_q,
  output logic [3:0]   flags_q,
  output logic         res_valid,
  output logic         op_err,
  output logic [2:0]   estado
);
  state_t st, st_n;
  logic next_p, clr_p, ld_a, ld_b, ld_op, cap, drop, bad_op;
  logic [3:0] opc;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst(rst), .btn(btn_next), .press(next_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(clk), .rst(rst), .btn(btn_clr), .press(clr_p)
  );
  assign opc    = 4'(sw);
  assign estado = st;
  assign op_err = bad_op & ~clr_p & ~rst;
  // next-state and register load strobes; EXEC advances on its own and ignores presses
  always_comb begin
    st_n   = st;
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    ld_op  = 1'b0;
    cap    = 1'b0;
    drop   = 1'b0;
    bad_op = 1'b0;
    case (st)
      ST_A: begin
        ld_a = next_p;
        st_n = next_p ? ST_B : ST_A;
      end
      ST_B: begin
        ld_b = next_p;
        st_n = next_p ? ST_OP : ST_B;
      end
      ST_OP: begin
        ld_op  = next_p & op_ok(opc);
        bad_op = next_p & ~op_ok(opc);
        st_n   = ld_op ? ST_EXEC : ST_OP;
      end
      ST_EXEC: begin
        cap  = 1'b1;
        st_n = ST_RES;
      end
      ST_RES: begin
        drop = next_p;
        st_n = next_p ? ST_A : ST_RES;
      end
      default: st_n = ST_A;
    endcase
  end
  // state and datapath registers; a clear press behaves exactly like reset here
  always_ff @(posedge clk)
    if (rst || clr_p) begin
      st        <= ST_A;
      a         <= '0;
      b         <= '0;
      seleccion <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      res_valid <= 1'b0;
    end else begin
      st        <= st_n;
      a         <= ld_a ? sw : a;
      b         <= ld_b ? sw : b;
      seleccion <= ld_op ? opc : seleccion;
      res_q     <= cap ? salida_in : res_q;
      flags_q   <= cap ? flags_in : flags_q;
      res_valid <= cap ? 1'b1 : drop ? 1'b0 : res_valid;
    end
endmodule

// File: tb/tb_calcu_input_seq.sv
// tb_calcu_input_seq: randomized self-checking bench with a press-level reference model and a behavioural ALU
module tb_calcu_input_seq;
  localparam int N = 4;
  localparam int HOLD = 24;
  logic clk = 1'b0, rst = 1'b1, btn_next = 1'b0, btn_clr = 1'b0;
  logic [N-1:0] sw = '0, a, b, salida_in, res_q;
  logic [3:0] seleccion, flags_in, flags_q;
  logic res_valid, op_err;
  logic [2:0] estado;
  int tests = 0, fails = 0, err_cycles = 0;
  logic [N-1:0] m_a, m_b, m_res;
  logic [3:0] m_sel, m_flags;
  logic m_valid;
  logic [2:0] m_st;

  always #5 clk = ~clk;

  calcu_input_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_clr(btn_clr),
    .a(a), .b(b), .seleccion(seleccion), .salida_in(salida_in), .flags_in(flags_in),
    .res_q(res_q), .flags_q(flags_q), .res_valid(res_valid), .op_err(op_err), .estado(estado)
  );

  function automatic logic [N+3:0] alu(input logic [N-1:0] x, input logic [N-1:0] y, input logic [3:0] op);
    logic [N:0] f;
    logic [N-1:0] r;
    logic dz;
    dz = (op == 4'd3 || op == 4'd4) && y == 0;
    case (op)
      4'd0: f = {1'b0, x} + {1'b0, y};
      4'd1: f = {1'b0, x} - {1'b0, y};
      4'd2: f = (N+1)'({1'b0, x} * {1'b0, y});
      4'd3: f = dz ? '0 : {1'b0, x % y};
      4'd4: f = dz ? '0 : {1'b0, x / y};
      4'd5: f = {1'b0, x & y};
      4'd6: f = {1'b0, x | y};
      4'd7: f = {1'b0, x ^ y};
      4'd8: f = {y, 1'b0};
      4'd9: f = {2'b0, y[N-1:1]};
      default: f = '0;
    endcase
    r = f[N-1:0];
    return {r == 0, f[N], r[N-1], dz, r};
  endfunction

  always_comb {flags_in, salida_in} = alu(a, b, seleccion);
  always @(posedge clk) if (op_err) err_cycles++;

  task automatic model_reset();
    m_a = '0; m_b = '0; m_sel = '0; m_res = '0; m_flags = '0; m_valid = 1'b0; m_st = 3'd0;
  endtask

  task automatic model_next(input logic [N-1:0] v);
    logic [3:0] op;
    op = 4'(v);
    case (m_st)
      3'd0: begin m_a = v; m_st = 3'd1; end
      3'd1: begin m_b = v; m_st = 3'd2; end
      3'd2: if (op <= 4'd9) begin
        m_sel = op; {m_flags, m_res} = alu(m_a, m_b, op); m_valid = 1'b1; m_st = 3'd4;
      end
      default: begin m_valid = 1'b0; m_st = 3'd0; end
    endcase
  endtask

  task automatic press_next(input logic [N-1:0] v);
    sw = v;
    @(negedge clk) btn_next = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_next = 1'b0;
    repeat (HOLD) @(negedge clk);
    model_next(v);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    tests++;
    if ({a, b, seleccion, res_q, flags_q, res_valid, op_err, estado} !== {m_a, m_b, m_sel, m_res, m_flags, m_valid, 1'b0, m_st}) begin
      fails++;
      $display("FAIL reset: got a=%0d b=%0d sel=%0d res=%0d flags=%h v=%b err=%b st=%0d", a, b, seleccion, res_q, flags_q, res_valid, op_err, estado);
    end
  endtask

  task automatic test_entry(input string name, input logic [N-1:0] va, input logic [N-1:0] vb, input logic [N-1:0] vop, input logic [N-1:0] want);
    logic [N-1:0] seq [4];
    seq = '{va, vb, vop, '0};
    for (int i = 0; i < 4; i++) begin
      press_next(seq[i]);
      tests++;
      if ({a, b, seleccion, res_q, flags_q, res_valid, estado} !== {m_a, m_b, m_sel, m_res, m_flags, m_valid, m_st}) begin
        fails++;
        $display("FAIL %s step%0d: got a=%0d b=%0d sel=%0d res=%0d flags=%h v=%b st=%0d want a=%0d b=%0d sel=%0d res=%0d flags=%h v=%b st=%0d",
                 name, i, a, b, seleccion, res_q, flags_q, res_valid, estado, m_a, m_b, m_sel, m_res, m_flags, m_valid, m_st);
      end
      if (i == 2) begin
        tests++;
        if (res_q !== want) begin
          fails++;
          $display("FAIL %s result: got %0d want %0d", name, res_q, want);
        end
      end
    end
  endtask

  task automatic test_bad_op();
    int e0;
    press_next(4'd6);
    press_next(4'd5);
    e0 = err_cycles;
    press_next(4'd12);
    tests++;
    if ({err_cycles - e0, estado, seleccion} !== {32'd1, 3'd2, m_sel}) begin
      fails++;
      $display("FAIL bad_op: got err_cycles=%0d st=%0d sel=%0d want 1 2 %0d", err_cycles - e0, estado, seleccion, m_sel);
    end
    e0 = err_cycles;
    press_next(4'd7);
    press_next(4'd0);
    tests++;
    if ({err_cycles - e0, estado, a} !== {32'd0, 3'd0, 4'd6}) begin
      fails++;
      $display("FAIL good_op_after_bad: got err_cycles=%0d st=%0d a=%0d want 0 0 6", err_cycles - e0, estado, a);
    end
  endtask

  task automatic test_latency();
`ifndef CALCU_DEBOUNCE_EN
    press_next(4'd9);
    press_next(4'd4);
    sw = 4'd1;
    @(negedge clk) btn_next = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if ({estado, res_valid} !== {3'd3, 1'b0}) begin
      fails++;
      $display("FAIL latency_exec: got st=%0d v=%b want 3 0", estado, res_valid);
    end
    @(negedge clk);
    tests++;
    if ({estado, res_valid, res_q} !== {3'd4, 1'b1, 4'd5}) begin
      fails++;
      $display("FAIL latency_res: got st=%0d v=%b res=%0d want 4 1 5", estado, res_valid, res_q);
    end
    btn_next = 1'b0;
    repeat (HOLD) @(negedge clk);
    model_next(4'd1);
    press_next(4'd0);
`endif
  endtask

  task automatic test_clr_same_cycle();
    press_next(4'd7);
    sw = 4'd9;
    @(negedge clk) begin btn_next = 1'b1; btn_clr = 1'b1; end
    repeat (HOLD) @(negedge clk);
    btn_next = 1'b0;
    btn_clr = 1'b0;
    repeat (HOLD) @(negedge clk);
    model_reset();
    tests++;
    if ({a, b, seleccion, res_valid, estado} !== {m_a, m_b, m_sel, m_valid, m_st}) begin
      fails++;
      $display("FAIL clr_with_next: got a=%0d b=%0d sel=%0d v=%b st=%0d want all 0", a, b, seleccion, res_valid, estado);
    end
  endtask

  task automatic test_rst_exec();
    int n;
    press_next(4'd11);
    press_next(4'd3);
    sw = 4'd2;
    n = 0;
    @(negedge clk) btn_next = 1'b1;
    while (estado !== 3'd3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (estado !== 3'd3) begin
      fails++;
      $display("FAIL rst_exec_reach: got st=%0d want 3 within 40 cycles", estado);
    end
    rst = 1'b1;
    btn_next = 1'b0;
    @(negedge clk);
    model_reset();
    tests++;
    if ({a, b, seleccion, res_q, flags_q, res_valid, estado} !== {m_a, m_b, m_sel, m_res, m_flags, m_valid, m_st}) begin
      fails++;
      $display("FAIL rst_exec: got a=%0d b=%0d sel=%0d res=%0d flags=%h v=%b st=%0d want all 0", a, b, seleccion, res_q, flags_q, res_valid, estado);
    end
    rst = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic test_random();
    int e0;
    logic [N-1:0] v;
    for (int it = 0; it < 8; it++) begin
      for (int s = 0; s < 4; s++) begin
        v = s == 2 ? N'($urandom_range(0, 15)) : N'($urandom);
        e0 = err_cycles;
        press_next(v);
        tests++;
        if ({a, b, seleccion, res_q, flags_q, res_valid, estado, err_cycles - e0} !==
            {m_a, m_b, m_sel, m_res, m_flags, m_valid, m_st, (s == 2 && v > 4'd9) ? 32'd1 : 32'd0}) begin
          fails++;
          $display("FAIL random it%0d step%0d sw=%0d: got a=%0d b=%0d sel=%0d res=%0d flags=%h v=%b st=%0d err=%0d want a=%0d b=%0d sel=%0d res=%0d flags=%h v=%b st=%0d",
                   it, s, v, a, b, seleccion, res_q, flags_q, res_valid, estado, err_cycles - e0, m_a, m_b, m_sel, m_res, m_flags, m_valid, m_st);
        end
        if (s == 2 && v > 4'd9) begin
          press_next(N'($urandom_range(0, 9)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry("add", 4'd3, 4'd2, 4'd0, 4'd5);
    test_entry("lshift", 4'd3, 4'd2, 4'd8, 4'd4);
    tests++;
    if ({estado, res_valid, a} !== {3'd0, 1'b0, 4'd3}) begin
      fails++;
      $display("FAIL return_to_a: got st=%0d v=%b a=%0d want 0 0 3", estado, res_valid, a);
    end
    test_bad_op();
    test_latency();
    test_clr_same_cycle();
    test_rst_exec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
